// File: rtl/dllp_axis_if.sv
// One-beat-per-DLLP AXI-Stream link from the DLLP scheduler toward the PHY TX mux.
// A beat transfers on a rising clock edge where tvalid && tready; once tvalid is high the
// source holds tdata/tkeep/tlast/tuser unchanged until that edge, and tvalid never depends on tready.
interface dllp_axis_if #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = 4,
  parameter int USER_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tready;

  modport master (output tdata, output tkeep, output tvalid, output tlast, output tuser,
                  input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, input tuser,
                  output tready);
endinterface

// File: rtl/dllp_tx_scheduler.sv
// Outbound DLLP scheduler: coalesced Ack, single-shot Nak and periodic VC0 UpdateFC,
// emitted as one 4-byte body per AXIS beat (CRC16 is appended downstream).
module dllp_tx_scheduler #(
  parameter int DATA_WIDTH      = 32,
  parameter int KEEP_WIDTH      = 4,
  parameter int USER_WIDTH      = 4,
  parameter int ACK_LATENCY     = 255,
  parameter int UPDATEFC_PERIOD = 4095
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  link_status_i,
  input  logic [11:0] seq_num_i,
  input  logic        seq_num_vld_i,
  input  logic        seq_num_acknack_i,
  input  logic [7:0]  rx_fc_ph_i,
  input  logic [11:0] rx_fc_pd_i,
  input  logic [7:0]  rx_fc_nph_i,
  input  logic [11:0] rx_fc_npd_i,
  input  logic [7:0]  rx_fc_cplh_i,
  input  logic [11:0] rx_fc_cpld_i,
  dllp_axis_if.master m_axis,
  output logic        dbg_state_o
);

  localparam int AW = $clog2(ACK_LATENCY + 1);
  localparam int FW = $clog2(UPDATEFC_PERIOD + 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_t;

  state_t                r_state;
  logic [11:0]           r_last_seq;
  logic                  r_ack_pending;
  logic                  r_nak_pending;
  logic                  r_nak_sent;
  logic [2:0]            r_fc_pending;
  logic [AW-1:0]         r_ack_timer;
  logic [FW-1:0]         r_fc_timer;
  logic                  r_was_active;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic [USER_WIDTH-1:0] r_tuser;
  logic                  r_tvalid;

  logic                  w_active;
  logic                  w_ack_due;
  logic                  w_idle_sel;
  logic                  w_sel_nak;
  logic                  w_sel_ack;
  logic                  w_sel_p;
  logic                  w_sel_np;
  logic                  w_sel_cpl;
  logic                  w_sel_any;
  logic                  w_fc_expire;
  logic                  w_cap_ack;
  logic                  w_cap_nak;
  logic [DATA_WIDTH-1:0] w_beat_data;
  logic [USER_WIDTH-1:0] w_beat_user;

  function automatic logic [31:0] fc_body(input logic [7:0] typ, input logic [7:0] hdr,
                                          input logic [11:0] data);
    return {data[7:0], hdr[1:0], 2'b00, data[11:8], 2'b00, hdr[7:2], typ};
  endfunction

  assign w_active   = (link_status_i == 2'b10);
  assign w_ack_due  = r_ack_pending && (r_ack_timer == AW'(ACK_LATENCY));
  assign w_idle_sel = w_active && (r_state == ST_IDLE);

  // Fixed priority: Nak, due Ack, then UpdateFC P, NP, Cpl.
  assign w_sel_nak = w_idle_sel && r_nak_pending;
  assign w_sel_ack = w_idle_sel && !r_nak_pending && w_ack_due;
  assign w_sel_p   = w_idle_sel && !r_nak_pending && !w_ack_due && r_fc_pending[0];
  assign w_sel_np  = w_idle_sel && !r_nak_pending && !w_ack_due && !r_fc_pending[0]
                     && r_fc_pending[1];
  assign w_sel_cpl = w_idle_sel && !r_nak_pending && !w_ack_due && !r_fc_pending[0]
                     && !r_fc_pending[1] && r_fc_pending[2];
  assign w_sel_any = w_sel_nak || w_sel_ack || w_sel_p || w_sel_np || w_sel_cpl;

  // The first active cycle counts as an expiry so a round goes out right after link-up.
  assign w_fc_expire = !r_was_active || (r_fc_timer == FW'(UPDATEFC_PERIOD));
  assign w_cap_ack   = w_active && seq_num_vld_i && seq_num_acknack_i;
  assign w_cap_nak   = w_active && seq_num_vld_i && !seq_num_acknack_i;

  always_comb begin
    w_beat_data = '0;
    w_beat_user = '0;
    if (w_sel_nak || w_sel_ack) begin
      w_beat_data = {r_last_seq[7:0], 4'h0, r_last_seq[11:8], 8'h00,
                     (w_sel_nak ? 8'h10 : 8'h00)};
      w_beat_user = 4'b0001;
    end else if (w_sel_p) begin
      w_beat_data = fc_body(8'h80, rx_fc_ph_i, rx_fc_pd_i);
      w_beat_user = 4'b0010;
    end else if (w_sel_np) begin
      w_beat_data = fc_body(8'h90, rx_fc_nph_i, rx_fc_npd_i);
      w_beat_user = 4'b0010;
    end else if (w_sel_cpl) begin
      w_beat_data = fc_body(8'hA0, rx_fc_cplh_i, rx_fc_cpld_i);
      w_beat_user = 4'b0010;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= ST_IDLE;
      r_last_seq    <= '0;
      r_ack_pending <= 1'b0;
      r_nak_pending <= 1'b0;
      r_nak_sent    <= 1'b0;
      r_fc_pending  <= '0;
      r_ack_timer   <= '0;
      r_fc_timer    <= '0;
      r_was_active  <= 1'b0;
      r_tdata       <= '0;
      r_tuser       <= '0;
      r_tvalid      <= 1'b0;
    end else begin
      // Output path runs regardless of link state so a held beat always completes.
      case (r_state)
        ST_IDLE: begin
          if (w_sel_any) begin
            r_tdata  <= w_beat_data;
            r_tuser  <= w_beat_user;
            r_tvalid <= 1'b1;
            r_state  <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (m_axis.tready) begin
            r_tdata  <= '0;
            r_tuser  <= '0;
            r_tvalid <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (!w_active) begin
        r_ack_pending <= 1'b0;
        r_nak_pending <= 1'b0;
        r_nak_sent    <= 1'b0;
        r_fc_pending  <= '0;
        r_ack_timer   <= '0;
        r_fc_timer    <= '0;
        r_was_active  <= 1'b0;
      end else begin
        r_was_active <= 1'b1;

        if (r_ack_pending && !w_ack_due) r_ack_timer <= r_ack_timer + 1'b1;

        if (w_sel_nak) begin
          r_nak_pending <= 1'b0;
          r_nak_sent    <= 1'b1;
          r_ack_pending <= 1'b0;
          r_ack_timer   <= '0;
        end
        if (w_sel_ack) begin
          r_ack_pending <= 1'b0;
          r_ack_timer   <= '0;
        end
        r_fc_pending <= r_fc_pending & ~{w_sel_cpl, w_sel_np, w_sel_p};

        // Captures come after the send-clears so a same-cycle capture keeps its bit set.
        if (w_cap_ack) begin
          r_last_seq    <= seq_num_i;
          r_ack_pending <= 1'b1;
          r_nak_sent    <= 1'b0;
          if (!r_ack_pending || w_sel_ack || w_sel_nak) r_ack_timer <= '0;
        end
        if (w_cap_nak) begin
          r_last_seq    <= seq_num_i;
          r_nak_pending <= !r_nak_sent;
        end

        if (w_fc_expire) begin
          r_fc_timer   <= '0;
          r_fc_pending <= 3'b111;
        end else begin
          r_fc_timer <= r_fc_timer + 1'b1;
        end
      end
    end
  end

  assign m_axis.tdata  = r_tdata;
  assign m_axis.tuser  = r_tuser;
  assign m_axis.tvalid = r_tvalid;
  assign m_axis.tlast  = r_tvalid;
  assign m_axis.tkeep  = {KEEP_WIDTH{r_tvalid}};
  assign dbg_state_o   = r_state;

endmodule
